// File: rtl/paddle_timing_ctrl.sv
// Per-frame paddle RC emulation: holds lp_in/rp_in low for <position> scanlines after each vsync.
// Outputs registered one clk_sys behind the line counters; no backpressure, event driven by hs/vs edges.
module paddle_timing_ctrl #(
  parameter int unsigned STEP_SLOW = 5,
  parameter int unsigned STEP_FAST = 8,
  parameter int unsigned POS_INIT  = 128
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        hs,
  input  logic        vs,
  input  logic        speed,
  input  logic        practice,
  input  logic [1:0]  p1_mode,
  input  logic [1:0]  p2_mode,
  input  logic        p1_invert,
  input  logic        p2_invert,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic [15:0] p1_analog,
  input  logic [15:0] p2_analog,
  input  logic [7:0]  p1_paddle,
  input  logic [7:0]  p2_paddle,
  output logic        lp_in,
  output logic        rp_in,
  output logic [7:0]  p1_pos,
  output logic [7:0]  p2_pos,
  output logic        busy
);

  typedef enum logic {IDLE, COUNT} state_e;

  localparam logic [8:0] STEP_SLOW_W = 9'(STEP_SLOW);
  localparam logic [8:0] STEP_FAST_W = 9'(STEP_FAST);
  localparam logic [7:0] POS_INIT_W  = 8'(POS_INIT);

  logic       hs_d_q, vs_d_q;
  logic       hs_rise, vs_rise;
  state_e     state_q [2];
  state_e     state_d [2];
  logic [8:0] cap_q   [2];
  logic [8:0] cap_d   [2];
  logic [7:0] pos_q   [2];
  logic [7:0] pos_d   [2];
  logic [7:0] load_v  [2];
  logic [8:0] up_res  [2];
  logic [8:0] dn_res  [2];
  logic [1:0] mode    [2];
  logic       up      [2];
  logic       down    [2];
  logic [8:0] step;
  logic       lp_in_q, rp_in_q, busy_q;
  logic       lp_in_d, rp_in_d, busy_d;

  // Analog axes are two's complement; flipping the MSB recentres them onto 0..255.
  function automatic logic [7:0] load_sel(input logic [1:0] m, input logic [7:0] pos,
                                          input logic [15:0] a, input logic [7:0] pad,
                                          input logic inv);
    logic [7:0] v;
    case (m)
      2'd0:    v = pos;
      2'd1:    v = {~a[15], a[14:8]};
      2'd2:    v = {~a[7], a[6:0]};
      default: v = pad;
    endcase
    return v ^ {8{inv}};
  endfunction

  assign hs_rise = hs & ~hs_d_q;
  assign vs_rise = vs & ~vs_d_q;
  assign step    = speed ? STEP_FAST_W : STEP_SLOW_W;

  assign mode[0] = p1_mode;
  assign mode[1] = p2_mode;
  assign up[0]   = p1_up;
  assign up[1]   = p2_up;
  assign down[0] = p1_down;
  assign down[1] = p2_down;

  assign load_v[0] = load_sel(p1_mode, pos_q[0], p1_analog, p1_paddle, p1_invert);
  assign load_v[1] = load_sel(p2_mode, pos_q[1], p2_analog, p2_paddle, p2_invert);

  // Both results go through bit 8 so wrap in either direction shows up as > 255.
  assign up_res[0] = {1'b0, pos_q[0]} - step;
  assign up_res[1] = {1'b0, pos_q[1]} - step;
  assign dn_res[0] = {1'b0, pos_q[0]} + step;
  assign dn_res[1] = {1'b0, pos_q[1]} + step;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cap_d[i]   = cap_q[i];
      pos_d[i]   = pos_q[i];
      if (vs_rise) begin
        cap_d[i]   = {1'b0, load_v[i]};
        state_d[i] = (load_v[i] != 8'd0) ? COUNT : IDLE;
        if (mode[i] == 2'd0) begin
          if (down[i]) begin
            pos_d[i] = (dn_res[i] > 9'd255) ? 8'hFF : dn_res[i][7:0];
          end else if (up[i]) begin
            pos_d[i] = (up_res[i] > 9'd255) ? 8'h00 : up_res[i][7:0];
          end
        end
      end else begin
        case (state_q[i])
          COUNT: begin
            if (cap_q[i] == 9'd0) begin
              state_d[i] = IDLE;
            end else if (hs_rise) begin
              cap_d[i] = cap_q[i] - 9'd1;
              if (cap_q[i] == 9'd1) state_d[i] = IDLE;
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    lp_in_d = (cap_q[0] == 9'd0);
    rp_in_d = practice ? (cap_q[0] == 9'd0) : (cap_q[1] == 9'd0);
    busy_d  = (|cap_q[0]) | (|cap_q[1]);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_d_q     <= 1'b0;
      vs_d_q     <= 1'b0;
      state_q[0] <= IDLE;
      state_q[1] <= IDLE;
      cap_q[0]   <= 9'd0;
      cap_q[1]   <= 9'd0;
      pos_q[0]   <= POS_INIT_W;
      pos_q[1]   <= POS_INIT_W;
      lp_in_q    <= 1'b1;
      rp_in_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      hs_d_q     <= hs;
      vs_d_q     <= vs;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      cap_q[0]   <= cap_d[0];
      cap_q[1]   <= cap_d[1];
      pos_q[0]   <= pos_d[0];
      pos_q[1]   <= pos_d[1];
      lp_in_q    <= lp_in_d;
      rp_in_q    <= rp_in_d;
      busy_q     <= busy_d;
    end
  end

  assign lp_in  = lp_in_q;
  assign rp_in  = rp_in_q;
  assign busy   = busy_q;
  assign p1_pos = pos_q[0];
  assign p2_pos = pos_q[1];

endmodule

// File: tb/tb_paddle_timing_ctrl.sv
// Scoreboard bench for paddle_timing_ctrl: driver pushes model expectations per clock,
// an independent monitor pops and compares them on the falling edge.
module tb_paddle_timing_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1, hs = 1'b0, vs = 1'b0, speed = 1'b0, practice = 1'b0;
  logic [1:0]  p1_mode = 2'd0, p2_mode = 2'd0;
  logic        p1_invert = 1'b0, p2_invert = 1'b0;
  logic        p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [15:0] p1_analog = 16'h0000, p2_analog = 16'h0000;
  logic [7:0]  p1_paddle = 8'd0, p2_paddle = 8'd0;
  logic        lp_in, rp_in, busy;
  logic [7:0]  p1_pos, p2_pos;

  typedef struct {
    bit lp;
    bit rp;
    bit busy;
    int p1;
    int p2;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  int m_cap [2];
  int m_pos [2];
  bit m_pvs, m_phs;

  paddle_timing_ctrl #(.STEP_SLOW(5), .STEP_FAST(8), .POS_INIT(128)) dut (
    .clk_sys(clk_sys), .reset(reset), .hs(hs), .vs(vs), .speed(speed), .practice(practice),
    .p1_mode(p1_mode), .p2_mode(p2_mode), .p1_invert(p1_invert), .p2_invert(p2_invert),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .p1_analog(p1_analog), .p2_analog(p2_analog), .p1_paddle(p1_paddle), .p2_paddle(p2_paddle),
    .lp_in(lp_in), .rp_in(rp_in), .p1_pos(p1_pos), .p2_pos(p2_pos), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Position source as an unsigned scanline count; analog axes are signed offsets from mid-scale.
  function automatic int load_val(input logic [1:0] m, input int pos, input logic [15:0] a,
                                  input logic [7:0] pad, input logic inv);
    int v;
    logic signed [7:0] s;
    case (m)
      2'd0: v = pos;
      2'd1: begin s = a[15:8]; v = int'(s) + 128; end
      2'd2: begin s = a[7:0];  v = int'(s) + 128; end
      default: v = int'(pad);
    endcase
    return inv ? 255 - v : v;
  endfunction

  function automatic int slew(input logic [1:0] m, input int pos, input logic u, input logic d);
    int st;
    st = speed ? 8 : 5;
    if (m != 2'd0) return pos;
    if (d) return (pos + st > 255) ? 255 : pos + st;
    if (u) return (pos - st < 0) ? 0 : pos - st;
    return pos;
  endfunction

  // Advance the model over the coming clock edge, queue what the outputs must show after it.
  task automatic step();
    exp_t e;
    bit vsr, hsr;
    if (reset) begin
      m_cap[0] = 0; m_cap[1] = 0; m_pos[0] = 128; m_pos[1] = 128;
      m_pvs = 1'b0; m_phs = 1'b0;
      e.lp = 1'b1; e.rp = 1'b1; e.busy = 1'b0; e.p1 = 128; e.p2 = 128;
    end else begin
      vsr = vs && !m_pvs;
      hsr = hs && !m_phs;
      e.lp   = (m_cap[0] == 0);
      e.rp   = practice ? (m_cap[0] == 0) : (m_cap[1] == 0);
      e.busy = (m_cap[0] != 0) || (m_cap[1] != 0);
      if (vsr) begin
        m_cap[0] = load_val(p1_mode, m_pos[0], p1_analog, p1_paddle, p1_invert);
        m_cap[1] = load_val(p2_mode, m_pos[1], p2_analog, p2_paddle, p2_invert);
        m_pos[0] = slew(p1_mode, m_pos[0], p1_up, p1_down);
        m_pos[1] = slew(p2_mode, m_pos[1], p2_up, p2_down);
      end else if (hsr) begin
        if (m_cap[0] > 0) m_cap[0]--;
        if (m_cap[1] > 0) m_cap[1]--;
      end
      e.p1 = m_pos[0];
      e.p2 = m_pos[1];
      m_pvs = vs;
      m_phs = hs;
    end
    exp_q.push_back(e);
    @(posedge clk_sys);
    #1;
  endtask

  task automatic frame(input int lines, input bit coincide);
    vs = 1'b1;
    hs = coincide;
    step();
    hs = 1'b0;
    step();
    vs = 1'b0;
    for (int l = 0; l < lines; l++) begin
      hs = 1'b1;
      repeat ($urandom_range(1, 2)) step();
      hs = 1'b0;
      repeat ($urandom_range(1, 2)) step();
    end
    step();
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    @(posedge clk_sys);
    forever begin
      @(negedge clk_sys);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("lp_in",  {7'd0, lp_in}, {7'd0, e.lp});
        check("rp_in",  {7'd0, rp_in}, {7'd0, e.rp});
        check("busy",   {7'd0, busy},  {7'd0, e.busy});
        check("p1_pos", p1_pos, 8'(e.p1));
        check("p2_pos", p2_pos, 8'(e.p2));
      end
    end
  end

  initial begin : driver
    int drain;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Default digital position: 128 lines on player 1.
    frame(135, 1'b0);

    p1_up = 1'b1;
    for (int f = 0; f < 30; f++) frame(2, 1'b0);
    p1_up = 1'b0; p1_down = 1'b1; speed = 1'b1;
    for (int f = 0; f < 40; f++) frame(2, 1'b0);
    p1_up = 1'b1;
    for (int f = 0; f < 3; f++) frame(2, 1'b0);
    p1_up = 1'b0; p1_down = 1'b0; speed = 1'b0;

    p1_mode = 2'd1; p1_analog = 16'h8000;
    frame(10, 1'b0);
    p1_analog = 16'h7F00;
    frame(260, 1'b0);
    p1_invert = 1'b1;
    frame(10, 1'b0);
    p1_invert = 1'b0; p1_mode = 2'd2; p1_analog = 16'h00F0;
    frame(20, 1'b0);

    p1_mode = 2'd3; p1_paddle = 8'd20; p2_mode = 2'd3; p2_paddle = 8'd40;
    frame(50, 1'b0);
    practice = 1'b1;
    frame(50, 1'b0);
    practice = 1'b0;

    // Retrigger while five lines remain, with hs rising on the same clock as vs.
    frame(15, 1'b0);
    frame(10, 1'b1);
    hs = 1'b1; vs = 1'b1;
    repeat (8) step();
    hs = 1'b0; vs = 1'b0;
    step();

    p1_mode = 2'd0; p1_paddle = 8'd100;
    frame(68, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    frame(135, 1'b0);

    for (int f = 0; f < 25; f++) begin
      p1_mode = 2'($urandom_range(0, 3));   p2_mode = 2'($urandom_range(0, 3));
      p1_invert = 1'($urandom);             p2_invert = 1'($urandom);
      p1_up = 1'($urandom);                 p1_down = 1'($urandom);
      p2_up = 1'($urandom);                 p2_down = 1'($urandom);
      p1_analog = 16'($urandom);            p2_analog = 16'($urandom);
      p1_paddle = 8'($urandom);             p2_paddle = 8'($urandom);
      speed = 1'($urandom);                 practice = 1'($urandom);
      frame($urandom_range(0, 280), $urandom_range(0, 3) == 0);
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk_sys);
      drain++;
    end
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
